// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register map indices and
// bus-decode helpers used by the register file.
package gpio_pkg;

  localparam logic [3:0] GPIO_OUT     = 4'd0;
  localparam logic [3:0] GPIO_OUT_SET = 4'd1;
  localparam logic [3:0] GPIO_OUT_CLR = 4'd2;
  localparam logic [3:0] GPIO_OUT_TGL = 4'd3;
  localparam logic [3:0] GPIO_DIR     = 4'd4;
  localparam logic [3:0] GPIO_IN      = 4'd5;
  localparam logic [3:0] GPIO_IE_RISE = 4'd6;
  localparam logic [3:0] GPIO_IE_FALL = 4'd7;
  localparam logic [3:0] GPIO_PEND    = 4'd8;

  function automatic logic is_read(input logic sel, input logic en, input logic [3:0] wen);
    return sel & en & (wen == 4'b0000);
  endfunction

  function automatic logic is_write(input logic sel, input logic [3:0] wen);
    return sel & (wen != 4'b0000);
  endfunction

  // Expands the four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] wen);
    return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Input synchroniser chain plus one-cycle history register, producing the
// synchronised pin value and its rising/falling edge strobes.
module gpio_sync #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '0;
      r_prev <= '0;
    end else begin
      r_stage[0] <= i_gpio;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
      r_prev <= r_stage[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: output/direction registers with atomic
// set/clear/toggle, synchronised inputs and edge-triggered interrupts.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_DIR   = '1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sel,
  input  logic             i_en,
  input  logic [3:0]       i_wen,
  input  logic [5:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  logic             w_rd;
  logic             w_wr;
  logic [3:0]       w_idx;
  logic [31:0]      w_laneMask;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_pendSet;
  logic [WIDTH-1:0] w_pendClr;
  logic [31:0]      w_rdMux;
  logic             w_unused;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_ieRise;
  logic [WIDTH-1:0] r_ieFall;
  logic [WIDTH-1:0] r_pend;
  logic [31:0]      r_rdata;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_gpio   (i_gpio),
    .o_sync   (w_sync),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_rd       = is_read(i_sel, i_en, i_wen);
  assign w_wr       = is_write(i_sel, i_wen);
  assign w_idx      = i_addr[5:2];
  assign w_laneMask = lane_mask(i_wen);
  assign w_mask     = w_laneMask[WIDTH-1:0];
  assign w_data     = i_wdata[WIDTH-1:0] & w_mask;
  assign w_unused   = ^{i_addr[1:0], i_wdata, w_laneMask};

  // A new edge in the same cycle as a write-1-clear keeps the bit set.
  assign w_pendSet = (w_rise & r_ieRise) | (w_fall & r_ieFall);
  assign w_pendClr = (w_wr && (w_idx == GPIO_PEND)) ? w_data : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out    <= '0;
      r_dir    <= RESET_DIR;
      r_ieRise <= '0;
      r_ieFall <= '0;
      r_pend   <= '0;
    end else begin
      if (w_wr) begin
        case (w_idx)
          GPIO_OUT:     r_out    <= (r_out & ~w_mask) | w_data;
          GPIO_OUT_SET: r_out    <= r_out | w_data;
          GPIO_OUT_CLR: r_out    <= r_out & ~w_data;
          GPIO_OUT_TGL: r_out    <= r_out ^ w_data;
          GPIO_DIR:     r_dir    <= (r_dir & ~w_mask) | w_data;
          GPIO_IE_RISE: r_ieRise <= (r_ieRise & ~w_mask) | w_data;
          GPIO_IE_FALL: r_ieFall <= (r_ieFall & ~w_mask) | w_data;
          default:      ;
        endcase
      end
      r_pend <= (r_pend & ~w_pendClr) | w_pendSet;
    end
  end

  always_comb begin
    w_rdMux = '0;
    case (w_idx)
      GPIO_OUT:     w_rdMux[WIDTH-1:0] = r_out;
      GPIO_DIR:     w_rdMux[WIDTH-1:0] = r_dir;
      GPIO_IN:      w_rdMux[WIDTH-1:0] = w_sync;
      GPIO_IE_RISE: w_rdMux[WIDTH-1:0] = r_ieRise;
      GPIO_IE_FALL: w_rdMux[WIDTH-1:0] = r_ieFall;
      GPIO_PEND:    w_rdMux[WIDTH-1:0] = r_pend;
      default:      ;
    endcase
  end

  // Read data is held between reads so the CPU-side mux sees a stable value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rdata <= '0;
    else if (w_rd)  r_rdata <= w_rdMux;
  end

  assign o_rdata   = r_rdata;
  assign o_gpio    = r_out;
  assign o_gpio_oe = r_dir;
  assign o_irq     = |r_pend;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: random bus traffic and pin activity
// against a behavioural model, plus directed scenarios from the register rules.
module tb_gpio_ctrl;

  localparam int W = 6;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          resetN;
  logic          sel, sel32, en;
  logic [3:0]    wen;
  logic [5:0]    addr;
  logic [31:0]   wdata;
  logic [W-1:0]  gpioIn;
  logic [31:0]   rdata;
  logic [W-1:0]  gpioOut, gpioOe;
  logic          irq;
  logic [31:0]   gpioIn32;
  logic [31:0]   rdata32, gpioOut32, gpioOe32;
  logic          irq32;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  mOut, mDir, mIeR, mIeF, mPend;
  logic [31:0]   mRdata;
  logic [W-1:0]  samples[$];

  gpio_ctrl dut (
    .i_clk(clk), .i_reset_n(resetN), .i_sel(sel), .i_en(en), .i_wen(wen),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .i_gpio(gpioIn),
    .o_gpio(gpioOut), .o_gpio_oe(gpioOe), .o_irq(irq)
  );

  gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2), .RESET_DIR(32'h0)) dut32 (
    .i_clk(clk), .i_reset_n(resetN), .i_sel(sel32), .i_en(en), .i_wen(wen),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata32), .i_gpio(gpioIn32),
    .o_gpio(gpioOut32), .o_gpio_oe(gpioOe32), .o_irq(irq32)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mOut = '0; mDir = '1; mIeR = '0; mIeF = '0; mPend = '0; mRdata = '0;
    samples = {};
    for (int i = 0; i < S + 1; i++) samples.push_back('0);
  endtask

  function automatic logic [31:0] modelRead(input int idx, input logic [W-1:0] syncV);
    logic [W-1:0] v;
    case (idx)
      0: v = mOut;
      4: v = mDir;
      5: v = syncV;
      6: v = mIeR;
      7: v = mIeF;
      8: v = mPend;
      default: v = '0;
    endcase
    return {{(32-W){1'b0}}, v};
  endfunction

  // Pin value seen by the block is the sample taken S-1 edges earlier.
  task automatic modelEdge();
    logic [W-1:0] syncV, prevV, setBits, m, d, nextPend;
    int idx;
    syncV    = samples[samples.size() - S];
    prevV    = samples[samples.size() - S - 1];
    setBits  = ((syncV & ~prevV) & mIeR) | ((~syncV & prevV) & mIeF);
    idx      = int'(addr[5:2]);
    for (int b = 0; b < W; b++) m[b] = wen[b / 8];
    d        = wdata[W-1:0] & m;
    nextPend = mPend;
    if (sel && en && wen == 4'b0) mRdata = modelRead(idx, syncV);
    if (sel && wen != 4'b0) begin
      case (idx)
        0: mOut = (mOut & ~m) | d;
        1: mOut = mOut | d;
        2: mOut = mOut & ~d;
        3: mOut = mOut ^ d;
        4: mDir = (mDir & ~m) | d;
        6: mIeR = (mIeR & ~m) | d;
        7: mIeF = (mIeF & ~m) | d;
        8: nextPend = mPend & ~d;
        default: ;
      endcase
    end
    mPend = nextPend | setBits;
    samples.push_back(gpioIn);
    if (samples.size() > S + 1) void'(samples.pop_front());
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".gpio_o"},  32'(gpioOut), 32'(mOut));
    checkOutput({tag, ".gpio_oe"}, 32'(gpioOe),  32'(mDir));
    checkOutput({tag, ".irq"},     32'(irq),     32'(|mPend));
    checkOutput({tag, ".rdata"},   rdata,        mRdata);
  endtask

  task automatic applyStimulus(input logic s, input logic e, input logic [3:0] w,
                               input logic [3:0] idx, input logic [31:0] d);
    sel = s; en = e; wen = w; wdata = d;
    addr = {idx, 2'($urandom)};
    tick();
    sel = 1'b0; en = 1'b0; wen = 4'b0;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, 4'hF, idx, d);
  endtask

  task automatic rd(input logic [3:0] idx);
    applyStimulus(1'b1, 1'b1, 4'h0, idx, 32'h0);
  endtask

  initial begin
    resetN = 1'b0; sel = 1'b0; sel32 = 1'b0; en = 1'b0; wen = 4'b0;
    addr = '0; wdata = '0; gpioIn = '0; gpioIn32 = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    checkAll("reset_init");
    checkOutput("reset_init.oe32", gpioOe32, 32'h0);

    for (int n = 0; n < 400; n++) begin
      sel   = ($urandom % 4) != 0;
      en    = 1'($urandom);
      wen   = (($urandom % 3) == 0) ? 4'h0 : 4'($urandom);
      addr  = (($urandom % 4) == 0) ? 6'($urandom) : {4'($urandom_range(0, 8)), 2'($urandom)};
      wdata = $urandom;
      if (($urandom % 3) == 0) gpioIn = W'($urandom);
      tick();
      checkAll("rand");
    end
    sel = 1'b0; en = 1'b0; wen = 4'b0;

    // Asynchronous reset arriving in the middle of a write to OUT.
    gpioIn = '0;
    wr(4'd0, 32'h3F);
    rd(4'd4);
    sel = 1'b1; en = 1'b1; wen = 4'hF; addr = 6'h00; wdata = 32'h15;
    #3 resetN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_mid.gpio_o",  32'(gpioOut), 32'h0);
    checkOutput("rst_mid.gpio_oe", 32'(gpioOe),  32'h3F);
    checkOutput("rst_mid.rdata",   rdata,        32'h0);
    checkOutput("rst_mid.irq",     32'(irq),     32'h0);
    sel = 1'b0; en = 1'b0; wen = 4'b0;
    #2 resetN = 1'b1;
    modelReset();
    rd(4'd0);
    checkOutput("rst_mid.out_rd", rdata, 32'h0);

    wr(4'd0, 32'h15); checkOutput("atomic.write", 32'(gpioOut), 32'h15);
    wr(4'd1, 32'h02); checkOutput("atomic.set",   32'(gpioOut), 32'h17);
    wr(4'd2, 32'h01); checkOutput("atomic.clr",   32'(gpioOut), 32'h16);
    wr(4'd3, 32'h30); checkOutput("atomic.tgl",   32'(gpioOut), 32'h26);
    rd(4'd0);         checkOutput("atomic.rd",    rdata,        32'h26);
    checkAll("atomic");

    sel32 = 1'b1; en = 1'b1; wen = 4'b0010; addr = 6'h10; wdata = 32'hFFFF_FFFF;
    tick();
    wen = 4'b0000;
    tick();
    checkOutput("lanes.dir_rd", rdata32,  32'h0000_FF00);
    checkOutput("lanes.oe32",   gpioOe32, 32'h0000_FF00);
    wen = 4'b1001; addr = 6'h00; wdata = 32'hA5A5_A5A5;
    tick();
    checkOutput("lanes.out32", gpioOut32, 32'hA500_00A5);
    sel32 = 1'b0; en = 1'b0; wen = 4'b0;

    // Step pin 3 just after an edge; it becomes visible two edges later.
    gpioIn = '0;
    repeat (4) tick();
    gpioIn[3] = 1'b1;
    tick();
    rd(4'd5); checkOutput("in_lat.edge2", 32'(rdata[3]), 32'h0);
    rd(4'd5); checkOutput("in_lat.edge3", 32'(rdata[3]), 32'h1);
    checkAll("in_lat");

    gpioIn = 6'b000010;
    repeat (4) tick();
    wr(4'd6, 32'h01);
    wr(4'd7, 32'h02);
    wr(4'd8, 32'h3F);
    checkOutput("irq.idle", 32'(irq), 32'h0);
    gpioIn = 6'b000001;
    tick();
    tick();
    checkOutput("irq.edge2", 32'(irq), 32'h0);
    tick();
    checkOutput("irq.edge3", 32'(irq), 32'h1);
    gpioIn = 6'b000010;
    rd(4'd8);          checkOutput("irq.pend",      rdata,     32'h03);
    wr(4'd8, 32'h01);
    rd(4'd8);          checkOutput("irq.pend_clr0", rdata,     32'h02);
    checkOutput("irq.still", 32'(irq), 32'h1);
    wr(4'd8, 32'h02);  checkOutput("irq.dropped",   32'(irq),  32'h0);
    checkAll("irq");

    repeat (4) tick();
    gpioIn = 6'b000011;
    tick();
    tick();
    wr(4'd8, 32'h01);
    checkOutput("collide.irq", 32'(irq), 32'h1);
    rd(4'd8);
    checkOutput("collide.pend", rdata, 32'h01);
    checkAll("collide");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
